// File: rtl/text_frame_ctrl.sv
// Text-mode frame controller: character buffer, 2-cycle pixel pipeline to an external glyph LUT, clear-screen FSM.
// Optional blinking inverted block cursor is enabled with the TEXT_FRAME_CURSOR_EN macro.
module text_frame_ctrl #(
  parameter int         COLS     = 80,
  parameter int         ROWS     = 60,
  parameter logic [7:0] CLR_CHAR = 8'h20
) (
  input  logic       clk,
  input  logic       rst,
`ifdef TEXT_FRAME_CURSOR_EN
  input  logic [6:0] cur_col,
  input  logic [5:0] cur_row,
  input  logic       cur_en,
`endif
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       pix_active,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       wr_val,
  output logic       wr_rdy,
  input  logic [6:0] wr_col,
  input  logic [5:0] wr_row,
  input  logic [7:0] wr_char,
  input  logic       clr_req,
  output logic       busy,
  output logic [7:0] lut_char,
  output logic [2:0] lut_vidx,
  output logic [2:0] lut_hidx,
  input  logic       lut_lit,
  output logic       pixel_on,
  output logic       active_out,
  output logic       hsync_out,
  output logic       vsync_out
);

  localparam int DEPTH = COLS * ROWS;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t        state_q;
  logic [AW-1:0] clr_addr_q;
  logic          busy_q;

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    rd_data_q;

  logic          mem_we_d;
  logic [AW-1:0] mem_waddr_d;
  logic [7:0]    mem_wdata_d;
  logic [AW-1:0] rd_addr_d;
  logic [6:0]    pix_col_d;
  logic [6:0]    pix_row_d;
  logic          pix_inr_d;
  logic          wr_fire_d;
  logic          wr_inr_d;

  logic          valid1_q, inr1_q, act1_q, hs1_q, vs1_q;
  logic [2:0]    vidx1_q, hidx1_q;
  logic          pixel_on_q, active_q, hs2_q, vs2_q;
  logic          pixel_on_d;

  // Clear wins over a simultaneous host write.
  assign wr_rdy = (state_q == S_IDLE) && !clr_req;
  assign busy   = busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_CLEAR;
      clr_addr_q <= '0;
      busy_q     <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (clr_req) begin
            state_q    <= S_CLEAR;
            clr_addr_q <= '0;
            busy_q     <= 1'b1;
          end
        end
        default: begin
          if (clr_addr_q == AW'(DEPTH - 1)) begin
            state_q    <= S_IDLE;
            clr_addr_q <= '0;
            busy_q     <= 1'b0;
          end else begin
            clr_addr_q <= clr_addr_q + 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    pix_col_d   = pix_x[9:3];
    pix_row_d   = pix_y[9:3];
    pix_inr_d   = (int'(pix_col_d) < COLS) && (int'(pix_row_d) < ROWS);
    rd_addr_d   = pix_inr_d ? (AW'(pix_row_d) * AW'(COLS) + AW'(pix_col_d)) : '0;
    wr_fire_d   = wr_val && wr_rdy;
    wr_inr_d    = (int'(wr_col) < COLS) && (int'(wr_row) < ROWS);
    mem_we_d    = 1'b0;
    mem_waddr_d = '0;
    mem_wdata_d = CLR_CHAR;
    if (state_q == S_CLEAR) begin
      mem_we_d    = 1'b1;
      mem_waddr_d = clr_addr_q;
    end else if (wr_fire_d && wr_inr_d) begin
      mem_we_d    = 1'b1;
      mem_waddr_d = AW'(wr_row) * AW'(COLS) + AW'(wr_col);
      mem_wdata_d = wr_char;
    end
  end

  // Plain array with a registered read so it maps onto block RAM (read-before-write).
  always_ff @(posedge clk) begin
    if (mem_we_d) mem_q[mem_waddr_d] <= mem_wdata_d;
    rd_data_q <= mem_q[rd_addr_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid1_q <= 1'b0;
      inr1_q   <= 1'b0;
      act1_q   <= 1'b0;
      hs1_q    <= 1'b1;
      vs1_q    <= 1'b1;
      vidx1_q  <= '0;
      hidx1_q  <= '0;
    end else begin
      valid1_q <= 1'b1;
      inr1_q   <= pix_inr_d;
      act1_q   <= pix_active;
      hs1_q    <= hsync_in;
      vs1_q    <= vsync_in;
      vidx1_q  <= pix_y[2:0];
      hidx1_q  <= pix_x[2:0];
    end
  end

  // valid1_q keeps the LUT outputs at zero until the first post-reset sample.
  assign lut_char = !valid1_q ? 8'h00 : (inr1_q ? rd_data_q : CLR_CHAR);
  assign lut_vidx = vidx1_q;
  assign lut_hidx = hidx1_q;

`ifdef TEXT_FRAME_CURSOR_EN
  logic       vs_prev_q;
  logic [5:0] frame_cnt_q;
  logic [6:0] col1_q, row1_q;
  logic       cur_hit_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_prev_q   <= 1'b1;
      frame_cnt_q <= '0;
      col1_q      <= '0;
      row1_q      <= '0;
    end else begin
      vs_prev_q <= vsync_in;
      if (vs_prev_q && !vsync_in) frame_cnt_q <= frame_cnt_q + 1'b1;
      col1_q <= pix_col_d;
      row1_q <= pix_row_d;
    end
  end

  assign cur_hit_d  = cur_en && frame_cnt_q[5] && (col1_q == cur_col) &&
                      (row1_q == {1'b0, cur_row}) && inr1_q;
  assign pixel_on_d = (lut_lit && act1_q && inr1_q) ^ cur_hit_d;
`else
  assign pixel_on_d = lut_lit && act1_q && inr1_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_on_q <= 1'b0;
      active_q   <= 1'b0;
      hs2_q      <= 1'b1;
      vs2_q      <= 1'b1;
    end else begin
      pixel_on_q <= pixel_on_d;
      active_q   <= act1_q;
      hs2_q      <= hs1_q;
      vs2_q      <= vs1_q;
    end
  end

  assign pixel_on   = pixel_on_q;
  assign active_out = active_q;
  assign hsync_out  = hs2_q;
  assign vsync_out  = vs2_q;

endmodule

// File: doc/text_frame_ctrl.md
Name: text_frame_ctrl

Overview:
- Text-mode frame controller for the VGA ASCII display.
- Holds a COLS x ROWS character buffer that a host writes into.
- For each pixel from the VGA timing generator, it looks up the character under that pixel and drives the external 8x8 glyph lookup with a character code, row index and column index.
- Registers the returned lit bit into a pixel output, keeping sync/active aligned. Also sequences a clear-screen (fill with space) operation.

Parameters:
- COLS, 80, text columns (640/8)
- ROWS, 60, text rows (480/8)
- CLR_CHAR, 8'h20, fill character written by clear

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- pix_x  in  10  current pixel column from timing generator
- pix_y  in  10  current pixel row from timing generator
- pix_active  in  1  pixel is in visible region
- hsync_in  in  1  horizontal sync, active-low
- vsync_in  in  1  vertical sync, active-low
- wr_val  in  1  host write request valid
- wr_rdy  out  1  controller accepts host write
- wr_col  in  7  target column
- wr_row  in  6  target row
- wr_char  in  8  ASCII code to store
- clr_req  in  1  pulse: start clear-screen
- busy  out  1  clear in progress
- lut_char  out  8  character code to glyph lookup
- lut_vidx  out  3  glyph row index
- lut_hidx  out  3  glyph column index
- lut_lit  in  1  combinational lit bit returned by glyph lookup
- pixel_on  out  1  pixel should be drawn
- active_out  out  1  pix_active delayed to match pixel_on
- hsync_out  out  1  hsync_in delayed to match pixel_on
- vsync_out  out  1  vsync_in delayed to match pixel_on

Behaviour:
- Reset:
  - pixel_on=0, active_out=0, hsync_out=1, vsync_out=1, lut_* = 0.
  - FSM enters CLEAR with the clear address at 0; busy=1, wr_rdy=0.
- Buffer: COLS*ROWS bytes, addr = row*COLS + col, synchronous read (1 cycle), one display read port, one write port.
- Display pipeline, total latency 2 cycles:
  - Cycle t: pix_x/pix_y/pix_active/syncs sampled. col = pix_x[9:3], row = pix_y[9:3]. Read issued at addr.
  - Cycle t+1:
    - Stage-1 registers hold the read data, vidx = pix_y[2:0] and hidx = pix_x[2:0].
    - A registered in-range flag is set when col<COLS and row<ROWS.
    - Active and syncs are also held in stage-1 registers.
    - lut_char = read data if in range, else CLR_CHAR. lut_vidx/lut_hidx come from the stage-1 registers.
  - Cycle t+2: pixel_on = lut_lit & active1 & inrange1. active_out, hsync_out and vsync_out are registered alongside pixel_on.
  - The pipeline runs every cycle regardless of FSM state. During CLEAR it displays partially cleared contents.
- FSM states:
  - IDLE: wr_rdy=1, busy=0.
    - A write fires when wr_val & wr_rdy.
    - The write is stored when wr_col<COLS and wr_row<ROWS. An out-of-range write is accepted and dropped.
    - clr_req=1 moves to CLEAR next cycle. The same cycle forces wr_rdy=0, so no write is accepted: clear wins.
  - CLEAR: busy=1, wr_rdy=0.
    - Writes CLR_CHAR at the clear address, then increments the address, one location per cycle.
    - After writing address COLS*ROWS-1, goes to IDLE and resets the address to 0. With defaults, CLEAR lasts exactly 4800 cycles.
    - clr_req during CLEAR is ignored (no restart).
- Reset mid-CLEAR or mid-write restarts CLEAR from address 0. A write in flight is lost.
- Read/write same address same cycle: read returns old data (read-before-write).

Optional Feature:
- Macro: TEXT_FRAME_CURSOR_EN.
- When defined, adds these ports:
  - cur_col in 7
  - cur_row in 6
  - cur_en in 1
- Adds a 6-bit frame counter that increments on each vsync_in falling edge (detected by a registered compare) and resets to 0.
- blink = frame_cnt[5], so the cursor toggles every 32 frames.
- pixel_on is XORed with 1 when all of the following hold at stage 1: cur_en, blink, stage-1 col==cur_col, row==cur_row, inrange. This gives an inverted block cursor.
- When not defined: no extra ports or logic, and pixel_on is exactly as above.

Test Plan:
- Reset, hold wr_val=1 → busy=1 and wr_rdy=0 for exactly 4800 cycles. busy falls and wr_rdy rises on cycle 4801. All locations then read back as 8'h20 (lut_char=8'h20 at every in-range pixel).
- After clear, write 'A' (8'h41) to col 0 row 0, then drive pix_x=2, pix_y=0, active=1 → lut_char=8'h41, vidx=0, hidx=2 at t+1. Glyph row 0x0C bit2=1 gives pixel_on=1 at t+2. pix_x=0 → pixel_on=0.
- pix_x=645, active=1, out of range (col 80) → lut_char=8'h20 and pixel_on=0, even if the glyph model returns lit=1.
- In IDLE, assert clr_req and wr_val together with col 5, row 5, 8'h42 → wr_rdy=0 that cycle. The write is not stored, and location (5,5) reads 8'h20 after the clear.
- Write to wr_col=100 → accepted (wr_rdy=1) and no buffer location changes. Toggle hsync_in/vsync_in → both appear on hsync_out/vsync_out exactly 2 cycles later.
- With TEXT_FRAME_CURSOR_EN, cursor at (1,1), cur_en=1, and 32 vsync falling edges applied → pixel_on is inverted across the 8x8 block at x 8-15, y 8-15. After 32 more edges the block is normal again.
